// File: rtl/frame_generator_pkg.sv
// frame_gen_pkg: shared types and constants for the frame generator.
//   state_e       : control FSM states
//   MD_*_LSB      : bit offsets of the metadata fields within the md beat
//   LFSR_SEED/TAPS: 32-bit Fibonacci LFSR, x^32+x^22+x^2+x+1
//   lfsr_next()   : one LFSR step (shift left, feedback into bit 0)
package frame_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_NEXT  = 2'd2
  } state_e;

  localparam int MD_IDX_LSB   = 0;
  localparam int MD_SIZE_LSB  = 32;
  localparam int MD_BEATS_LSB = 64;

  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
  // Taps at exponents 32, 22, 2, 1 -> state bits 31, 21, 1, 0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/frame_generator_if.sv
// frame_generator_if: the two AXI-Stream links driven by the frame generator.
//   axis_df_* : frame data stream (tdata DW bits, tvalid, tready)
//   axis_md_* : metadata stream   (tdata DW bits, tvalid, tready)
//   modport master : generator side
//   modport slave  : consumer side
interface frame_generator_if #(
  parameter int DW = 512
);
  logic [DW-1:0] axis_df_tdata;
  logic          axis_df_tvalid;
  logic          axis_df_tready;
  logic [DW-1:0] axis_md_tdata;
  logic          axis_md_tvalid;
  logic          axis_md_tready;

  modport master (
    output axis_df_tdata, axis_df_tvalid, input axis_df_tready,
    output axis_md_tdata, axis_md_tvalid, input axis_md_tready
  );

  modport slave (
    input  axis_df_tdata, axis_df_tvalid, output axis_df_tready,
    input  axis_md_tdata, axis_md_tvalid, output axis_md_tready
  );
endinterface

// File: rtl/frame_generator_lfsr32.sv
// lfsr32: 32-bit Fibonacci LFSR used as the data-lane pattern source.
// Only compiled when FRAMEGEN_LFSR_EN is defined.
//   clk, resetn : clock, synchronous active-low reset (state -> seed)
//   load        : reseed to LFSR_SEED (wins over advance)
//   advance     : step once
//   q[31:0]     : current state
`ifdef FRAMEGEN_LFSR_EN
module lfsr32
  import frame_gen_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] q
);
  logic [31:0] lfsr_d, lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)         lfsr_d = LFSR_SEED;
    else if (advance) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (!resetn) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;
endmodule
`endif

// File: rtl/frame_generator.sv
// frame_generator: synthetic frame source for the datapath AXI-Stream inputs.
// A start strobe launches frames_to_generate frames of frame_size bytes;
// each frame is ceil(frame_size/(DW/8)) data beats (minimum 1) plus one
// metadata beat {beats, frame_size, frame_idx}.
//   clk, resetn            : clock, synchronous active-low reset
//   start                  : launch strobe (ignored unless idle)
//   frames_to_generate     : frame count, sampled on start (0 = ignored)
//   frame_size             : bytes per frame, sampled on start
//   idle                   : registered, high when no run is active/pending
//   axis (master)          : df data stream and md metadata stream
// Build option FRAMEGEN_LFSR_EN: data lanes carry a 32-bit LFSR word,
// reseeded on start, stepped per accepted data beat. Default: lanes carry
// {frame_idx[15:0], beat_idx[15:0]}.
//
// state   | meaning
// S_IDLE  | no run; an accepted start sets start_pend and leaves next cycle
// S_FRAME | df and md beats of the current frame in flight, independently
// S_NEXT  | one-cycle gap; advance frame_idx, end run or start next frame
module frame_generator
  import frame_gen_pkg::*;
#(
  parameter int DW = 512
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] frames_to_generate,
  input  logic [31:0] frame_size,
  output logic        idle,
  frame_generator_if.master axis
);
  localparam int BYTES = DW / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int LANES = DW / 32;

  state_e      state_d, state_q;
  logic        start_pend_d, start_pend_q;
  logic        idle_d, idle_q;
  logic        df_valid_d, df_valid_q;
  logic        md_valid_d, md_valid_q;
  logic [31:0] count_d, count_q;
  logic [31:0] size_d, size_q;
  logic [31:0] beats_d, beats_q;
  logic [31:0] frame_idx_d, frame_idx_q;
  logic [31:0] beat_idx_d, beat_idx_q;

  logic        start_ok;
  logic        df_fire, md_fire, df_last;
  logic [32:0] size_round;
  logic [31:0] beats_calc;
  logic [31:0] lane_word;
  logic [DW-1:0] md_word;

  assign start_ok = (state_q == S_IDLE) && !start_pend_q && start &&
                    (frames_to_generate != 32'd0);
  assign df_fire  = df_valid_q && axis.axis_df_tready;
  assign md_fire  = md_valid_q && axis.axis_md_tready;
  assign df_last  = df_fire && (beat_idx_q == beats_q - 32'd1);

  // 33-bit round-up so frame_size near 2^32 does not overflow; a zero-byte
  // frame still emits one data beat.
  always_comb begin
    size_round = {1'b0, frame_size} + 33'(BYTES - 1);
    beats_calc = 32'(size_round >> SHIFT);
    if (beats_calc == 32'd0) beats_calc = 32'd1;
  end

  always_comb begin
    state_d      = state_q;
    start_pend_d = start_pend_q;
    df_valid_d   = df_valid_q;
    md_valid_d   = md_valid_q;
    count_d      = count_q;
    size_d       = size_q;
    beats_d      = beats_q;
    frame_idx_d  = frame_idx_q;
    beat_idx_d   = beat_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start_pend_q) begin
          start_pend_d = 1'b0;
          state_d      = S_FRAME;
          df_valid_d   = 1'b1;
          md_valid_d   = 1'b1;
        end else if (start_ok) begin
          start_pend_d = 1'b1;
          count_d      = frames_to_generate;
          size_d       = frame_size;
          beats_d      = beats_calc;
          frame_idx_d  = 32'd0;
          beat_idx_d   = 32'd0;
        end
      end
      S_FRAME: begin
        if (df_fire) beat_idx_d = beat_idx_q + 32'd1;
        if (df_last) df_valid_d = 1'b0;
        if (md_fire) md_valid_d = 1'b0;
        // Leave as soon as the final handshake of either stream lands,
        // so the gap between frames is exactly the S_NEXT cycle.
        if ((!df_valid_q || df_last) && (!md_valid_q || md_fire))
          state_d = S_NEXT;
      end
      S_NEXT: begin
        frame_idx_d = frame_idx_q + 32'd1;
        if (frame_idx_q + 32'd1 == count_q) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_FRAME;
          beat_idx_d = 32'd0;
          df_valid_d = 1'b1;
          md_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    idle_d = (state_d == S_IDLE) && !start_pend_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      start_pend_q <= 1'b0;
      idle_q       <= 1'b1;
      df_valid_q   <= 1'b0;
      md_valid_q   <= 1'b0;
      count_q      <= 32'd0;
      size_q       <= 32'd0;
      beats_q      <= 32'd0;
      frame_idx_q  <= 32'd0;
      beat_idx_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      idle_q       <= idle_d;
      df_valid_q   <= df_valid_d;
      md_valid_q   <= md_valid_d;
      count_q      <= count_d;
      size_q       <= size_d;
      beats_q      <= beats_d;
      frame_idx_q  <= frame_idx_d;
      beat_idx_q   <= beat_idx_d;
    end
  end

`ifdef FRAMEGEN_LFSR_EN
  lfsr32 u_lfsr (
    .clk     (clk),
    .resetn  (resetn),
    .load    (start_ok),
    .advance (df_fire),
    .q       (lane_word)
  );
`else
  assign lane_word = {frame_idx_q[15:0], beat_idx_q[15:0]};
`endif

  always_comb begin
    md_word = '0;
    md_word[MD_IDX_LSB   +: 32] = frame_idx_q;
    md_word[MD_SIZE_LSB  +: 32] = size_q;
    md_word[MD_BEATS_LSB +: 32] = beats_q;
  end

  // tdata is forced to zero whenever its stream is not valid; the source
  // registers only change on acceptance, so payload holds while stalled.
  assign axis.axis_df_tdata  = df_valid_q ? {LANES{lane_word}} : '0;
  assign axis.axis_df_tvalid = df_valid_q;
  assign axis.axis_md_tdata  = md_valid_q ? md_word : '0;
  assign axis.axis_md_tvalid = md_valid_q;
  assign idle                = idle_q;

endmodule

// File: tb/tb_frame_generator.sv
module tb_frame_generator;
  localparam int DW = 512;
  localparam int LANES = DW / 32;

  typedef struct {
    logic [DW-1:0] data;
    int            frame;
    int            beat;
    bit            last;
  } beat_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] frames_to_generate = '0;
  logic [31:0] frame_size = '0;
  logic        idle;
  logic        df_rdy = 1'b1;
  logic        md_rdy = 1'b1;
  int          df_mode = 0;
  int          md_mode = 0;

  frame_generator_if #(.DW(DW)) ifc ();
  assign ifc.axis_df_tready = df_rdy;
  assign ifc.axis_md_tready = md_rdy;

  frame_generator #(.DW(DW)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .start              (start),
    .frames_to_generate (frames_to_generate),
    .frame_size         (frame_size),
    .idle               (idle),
    .axis               (ifc)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  beat_t df_q[$];
  beat_t md_q[$];
  int df_frames_done = 0;
  int md_acc = 0;
  int df_acc_total = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input bit ok, input int act, input int exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [31:0] w);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = w;
    return r;
  endfunction

  // Reference model: expand a run into the exact beat lists both streams must emit.
  task automatic push_run(input longint unsigned frames, input longint unsigned size);
    longint unsigned beats;
    logic [31:0] lfsr;
    logic [DW-1:0] md;
    beat_t e;
    beats = (size == 0) ? 1 : (size + DW/8 - 1) / (DW/8);
    lfsr = 32'h1;
    df_frames_done = 0;
    md_acc = 0;
    df_acc_total = 0;
    for (longint unsigned f = 0; f < frames; f++) begin
      md = '0;
      md[31:0]  = 32'(f);
      md[63:32] = 32'(size);
      md[95:64] = 32'(beats);
      e.data = md; e.frame = int'(f); e.beat = 0; e.last = 1'b1;
      md_q.push_back(e);
      for (longint unsigned b = 0; b < beats; b++) begin
`ifdef FRAMEGEN_LFSR_EN
        e.data = rep(lfsr);
        lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
`else
        e.data = rep({f[15:0], b[15:0]});
`endif
        e.frame = int'(f); e.beat = int'(b); e.last = (b == beats - 1);
        df_q.push_back(e);
      end
    end
  endtask

  // Compare process: every presented beat must be the model's next beat,
  // and a stream may not present frame f before frame f-1 finished on the other.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ifc.axis_df_tvalid) begin
        if (df_q.size() == 0) begin
          flag("df_spurious_valid", 1'b0, 1, 0);
        end else begin
          chk("df_data", ifc.axis_df_tdata, df_q[0].data);
          flag("df_frame_order", md_acc >= df_q[0].frame, md_acc, df_q[0].frame);
          if (ifc.axis_df_tready) begin
            if (df_q[0].last) df_frames_done++;
            df_acc_total++;
            void'(df_q.pop_front());
          end
        end
      end
      if (ifc.axis_md_tvalid) begin
        if (md_q.size() == 0) begin
          flag("md_spurious_valid", 1'b0, 1, 0);
        end else begin
          chk("md_data", ifc.axis_md_tdata, md_q[0].data);
          flag("md_frame_order", df_frames_done >= md_q[0].frame, df_frames_done, md_q[0].frame);
          if (ifc.axis_md_tready) begin
            md_acc++;
            void'(md_q.pop_front());
          end
        end
      end
    end
  end

  bit tog = 1'b0;
  always @(posedge clk) begin
    #1;
    tog = ~tog;
    case (df_mode)
      0: df_rdy = 1'b1;
      1: df_rdy = 1'($urandom_range(0, 1));
      2: df_rdy = tog;
      default: df_rdy = 1'b0;
    endcase
    case (md_mode)
      0: md_rdy = 1'b1;
      1: md_rdy = 1'($urandom_range(0, 1));
      2: md_rdy = ~tog;
      default: md_rdy = 1'b0;
    endcase
  end

  task automatic do_start(input int unsigned frames, input int unsigned size, input bit accept);
    @(posedge clk); #1;
    start = 1'b1;
    frames_to_generate = frames;
    frame_size = size;
    if (accept) push_run(frames, size);
    @(posedge clk); #1;
    start = 1'b0;
    frames_to_generate = $urandom;
    frame_size = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!idle && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    flag({name, "_idle_timeout"}, idle === 1'b1, n, 5000);
    flag({name, "_df_drained"}, df_q.size() == 0, df_q.size(), 0);
    flag({name, "_md_drained"}, md_q.size() == 0, md_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] first_lane;
    logic [95:0] md_lo;
`ifdef FRAMEGEN_LFSR_EN
    first_lane = 32'h0000_0001;
`else
    first_lane = 32'h0000_0000;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_idle", idle, 1'b1);
    chk("reset_df_valid", ifc.axis_df_tvalid, 1'b0);
    chk("reset_md_valid", ifc.axis_md_tvalid, 1'b0);
    chk("reset_df_data", ifc.axis_df_tdata, '0);
    chk("reset_md_data", ifc.axis_md_tdata, '0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Basic run: 200 bytes -> 4 beats, idle back 6 cycles after start.
    df_mode = 0; md_mode = 0;
    do_start(1, 200, 1);
    chk("basic_idle_drops", idle, 1'b0);
    chk("basic_valid_latency", ifc.axis_df_tvalid, 1'b0);
    @(posedge clk); #1;
    n = 1;
    chk("basic_df_valid", ifc.axis_df_tvalid, 1'b1);
    chk("basic_md_valid", ifc.axis_md_tvalid, 1'b1);
    chk("basic_lane0", ifc.axis_df_tdata[31:0], first_lane);
    md_lo = ifc.axis_md_tdata[95:0];
    chk("basic_md_fields", md_lo, {32'd4, 32'd200, 32'd0});
    while (!idle && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    flag("basic_idle_cycles", n == 6, n, 6);
    wait_idle("basic");

    // Multi-frame with data backpressure toggling.
    df_mode = 2; md_mode = 0;
    do_start(3, 64, 1);
    wait_idle("multi");

    // Metadata stalled: frame 0 data completes, frame 1 must not begin.
    df_mode = 0; md_mode = 3;
    do_start(2, 64, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("mdstall_df_valid", ifc.axis_df_tvalid, 1'b0);
    chk("mdstall_md_valid", ifc.axis_md_tvalid, 1'b1);
    flag("mdstall_df_frames", df_frames_done == 1, df_frames_done, 1);
    md_mode = 0;
    wait_idle("mdstall");

    // Zero frame count is ignored.
    do_start(0, 100, 0);
    for (int i = 0; i < 8; i++) begin
      chk("zero_count_idle", idle, 1'b1);
      @(posedge clk); #1;
    end

    // Zero frame size: one data beat per frame.
    do_start(2, 0, 1);
    @(posedge clk); #1;
    chk("zero_size_beats", ifc.axis_md_tdata[95:64], 32'd1);
    wait_idle("zero_size");

    // Start while busy is ignored; the original count is honoured.
    df_mode = 1; md_mode = 1;
    do_start(2, 128, 1);
    repeat (3) @(posedge clk);
    do_start(5, 64, 0);
    wait_idle("busy_start");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("busy_stays_idle", idle, 1'b1);
    end

    // Mid-run reset during beat 2 of frame 1 (4 beats per frame).
    df_mode = 0; md_mode = 0;
    do_start(3, 256, 1);
    n = 0;
    while (df_acc_total < 6 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    flag("midreset_reach_beat", df_acc_total == 6, df_acc_total, 6);
    chk("midreset_pending_valid", ifc.axis_df_tvalid, 1'b1);
    mon_en = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("midreset_df_valid", ifc.axis_df_tvalid, 1'b0);
    chk("midreset_md_valid", ifc.axis_md_tvalid, 1'b0);
    chk("midreset_idle", idle, 1'b1);
    df_q.delete();
    md_q.delete();
    resetn = 1'b1;
    mon_en = 1'b1;
    do_start(2, 64, 1);
    @(posedge clk); #1;
    chk("midreset_restart_idx", ifc.axis_md_tdata[31:0], 32'd0);
    wait_idle("midreset_restart");

    // Randomized runs: random sizes, counts and ready patterns.
    for (int r = 0; r < 14; r++) begin
      df_mode = int'($urandom_range(0, 2));
      md_mode = int'($urandom_range(0, 2));
      do_start($urandom_range(1, 4), $urandom_range(0, 400), 1);
      wait_idle("random");
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_generator.md
# frame_generator

Synthetic frame source that sits directly upstream of `datapath`, driving its frame-data (`axis_df`) and metadata (`axis_md`) AXI-Stream inputs. A one-cycle `start` strobe launches a run of `frames_to_generate` frames. Each frame is `frame_size` bytes of patterned data plus exactly one metadata beat. `idle` reports run completion back to the AXI4-Lite register block.

## Interface
- `DW`, 512: stream data width in bits; power of two, minimum 64.
- `clk`  in  1  clock.
- `resetn`  in  1  reset. Synchronous, active-low.
- `start`  in  1  one-cycle launch strobe.
- `frames_to_generate`  in  32  frame count, sampled on `start`.
- `frame_size`  in  32  frame length in bytes, sampled on `start`.
- `idle`  out  1  high when no run is active.
- `axis_df_tdata`  out  DW  frame data.
- `axis_df_tvalid`  out  1  frame data valid.
- `axis_df_tready`  in  1  frame data ready.
- `axis_md_tdata`  out  DW  metadata.
- `axis_md_tvalid`  out  1  metadata valid.
- `axis_md_tready`  in  1  metadata ready.

## Operation
- **Reset values:** `idle`=1; both `tvalid`=0; both `tdata`=0; all counters=0.
- **States:** S_IDLE, S_FRAME, S_NEXT.
- **S_IDLE**
  - `start`=1 with `frames_to_generate`≠0: latch count and size, set frame_idx=0, go to S_FRAME.
  - `start` with count=0 is ignored.
  - `start` is ignored in any state other than S_IDLE.
- **Beats per frame:** beats = ceil(frame_size / (DW/8)), computed as `(frame_size + DW/8 - 1) >> log2(DW/8)` in 33-bit arithmetic. frame_size=0 yields beats=1. Latched once per run.
- **S_FRAME**
  - On entry, assert `axis_md_tvalid` and `axis_df_tvalid` together. The two streams progress independently.
  - md beat:
    - [31:0] = frame_idx
    - [63:32] = frame_size
    - [95:64] = beats
    - remaining bits 0
  - Data beat b: every 32-bit lane = {frame_idx[15:0], b[15:0]}.
  - A data beat is accepted on `tvalid&tready`; beat_idx then increments.
  - After the last beat (beat_idx = beats−1) is accepted, `axis_df_tvalid` drops.
  - After the md beat is accepted, `axis_md_tvalid` drops.
  - Once both streams are done, go to S_NEXT. Either stream may finish first.
- **S_NEXT**
  - Increment frame_idx.
  - If frame_idx+1 = count, go to S_IDLE. Otherwise clear beat_idx and go to S_FRAME.
- **Wrap:** frame_idx and beat_idx are 32-bit and wrap modulo 2^32. The data pattern uses only the low 16 bits of each.

## Timing
- `tvalid` rises on the edge after the `start` edge (1-cycle latency).
- AXIS rules:
  - `tvalid` never depends combinationally on `tready`.
  - Once asserted, `tdata` and `tvalid` hold stable until accepted.
- Back-to-back data beats sustain 1 beat/cycle while `tready`=1.
- Inter-frame gap: one idle cycle (S_NEXT) on both streams.
- `idle` drops on the edge after an accepted `start`. It rises on the edge that enters S_IDLE.
- `idle` is a registered output: state==S_IDLE and no `start` is pending.
- **Mid-run reset:** `resetn`=0 forces both `tvalid` low and `idle` high on that edge, even while a beat is pending. Partial frames are not completed.
- `start` on the same edge as the final S_NEXT→S_IDLE transition is ignored.

## Configuration
- **`FRAMEGEN_LFSR_EN` defined:** data lanes carry a 32-bit Fibonacci LFSR.
  - Polynomial x^32+x^22+x^2+x+1.
  - Seeded to 32'h1 on `start`.
  - Advances once per accepted data beat.
  - All lanes carry the same LFSR word.
- **`FRAMEGEN_LFSR_EN` undefined:** the counter pattern above; no LFSR logic is synthesized.
- Metadata format is identical in both builds.

## Structure
- **Package `frame_gen_pkg`:**
  - state enum (S_IDLE, S_FRAME, S_NEXT)
  - metadata field offsets: MD_IDX_LSB=0, MD_SIZE_LSB=32, MD_BEATS_LSB=64
  - LFSR seed and tap constants
- **Sub-module `lfsr32`:** clk, resetn, `load`, `advance`, `q[31:0]`. Instantiated only under `FRAMEGEN_LFSR_EN`.

## Test plan
- **Basic run:** DW=512, frame_size=200, frames=1, both `tready`=1.
  - 4 data beats with lanes 0x0000_0000..0x0000_0003.
  - One md beat with low 96 bits = {4, 200, 0}.
  - `idle` rises 6 cycles after `start`.
- **Multi-frame with backpressure:** frame_size=64, frames=3, `axis_df_tready` toggling 1/0.
  - 3 frames of 1 beat each, lanes 0x0000_0000 / 0x0001_0000 / 0x0002_0000.
  - `tdata` stable while stalled.
- **Metadata stall:** `axis_md_tready`=0 for 20 cycles, data ready.
  - Data finishes frame 0.
  - Frame 1 does not start until the md beat is accepted.
- **Degenerate starts:**
  - frames=0: no `tvalid`, `idle` stays 1.
  - frame_size=0: exactly 1 data beat per frame.
  - `start` while busy: ignored, original count honoured.
- **Mid-run reset:** `resetn`=0 during beat 2 of frame 1. Next cycle: both `tvalid`=0, `idle`=1. A new `start` begins at frame_idx 0.
- **LFSR build (`FRAMEGEN_LFSR_EN`):** frame_size=128. Lanes are 0x0000_0001, then the next LFSR state; the sequence is reseeded on the next `start`.
